pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control block that generates the `flush`, freeze and global-stall controls consumed by the IF/ID and ID/EX stage registers of the 5-stage ARM-subset core. It detects RAW data hazards between the instruction in ID and the instructions in EXE and MEM. It turns a taken branch in EXE into a two-register flush, and it holds the whole pipeline while the data-memory (SRAM) port is busy. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `FORWARD_EN`, 1: 1 means a forwarding unit exists, so only EXE-stage load-use stalls; 0 means stall on any RAW match in EXE or MEM.
- `INIT_FLUSH`, 2: number of cycles after reset release during which both stage registers are flushed (1..15).
- `MEM_TIMEOUT`, 255: number of MEM_WAIT cycles before `mem_timeout_err` is set (1..65535).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_src_1`  in  4  Rn index of the instruction in ID.
- `id_src_2`  in  4  Rm/Rd-store index of the instruction in ID.
- `id_uses_rn`  in  1  ID instruction reads `id_src_1`.
- `id_two_src`  in  1  ID instruction reads `id_src_2`.
- `exe_dest`  in  4  Dest output of the ID/EX register.
- `exe_wb_en`  in  1  WB_EN output of the ID/EX register.
- `exe_mem_r_en`  in  1  MEM_R_EN output of the ID/EX register.
- `exe_b`  in  1  B output of the ID/EX register (taken branch in EXE).
- `mem_dest`  in  4  destination register in the MEM stage.
- `mem_wb_en`  in  1  write-back enable in the MEM stage.
- `mem_req`  in  1  MEM stage issues a read or write to SRAM this cycle.
- `mem_ready`  in  1  SRAM completes the access this cycle.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `freeze_if`  out  1  hold PC and the IF/ID register.
- `flush_if_id`  out  1  clear the IF/ID register.
- `flush_id_ex`  out  1  drives the ID/EX register `flush` (inserts a bubble).
- `stall_all`  out  1  hold every pipeline register; overrides everything else.
- `stall_cnt`  out  32  number of cycles with `freeze_if` or `stall_all` high.
- `flush_cnt`  out  32  number of branch-flush cycles.
- `mem_timeout_err`  out  1  sticky error flag.

## Operation
- States:
  - STARTUP: entered on reset.
  - RUN
  - MEM_WAIT
- **STARTUP:**
  - `freeze_if`=1, `flush_if_id`=1, `flush_id_ex`=1, `stall_all`=0.
  - A 4-bit init counter counts to `INIT_FLUSH`, then the block moves to RUN.
- **RUN, checked in this priority order:**
  1. **Memory wait:** `mem_req` and not `mem_ready`. Drive `stall_all`=1 with all other outputs 0, and go to MEM_WAIT.
  2. **Branch:** `exe_b`=1. Drive `flush_if_id`=1, `flush_id_ex`=1, `freeze_if`=0. The branch beats any data hazard in the same cycle.
  3. **Data hazard:** drive `freeze_if`=1, `flush_id_ex`=1, `flush_if_id`=0.
  4. **Otherwise:** all outputs 0.
- **Data-hazard match:**
  - Define `m1` = `id_uses_rn` && `src_1` == dest, and `m2` = `id_two_src` && `src_2` == dest.
  - With `FORWARD_EN`=1: hazard = `exe_mem_r_en` && `exe_wb_en` && (`m1` || `m2` against `exe_dest`).
  - With `FORWARD_EN`=0: hazard = (`exe_wb_en` && `m1`/`m2` against `exe_dest`) || (`mem_wb_en` && `m1`/`m2` against `mem_dest`).
- **MEM_WAIT:**
  - `stall_all`=1 until a cycle with `mem_ready`=1.
  - In that cycle `stall_all`=0, the RUN rules apply to the current inputs, and the next state is RUN.
  - A 16-bit wait counter clears on entry and increments each MEM_WAIT cycle.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout_err` is set. The block keeps waiting; there is no abort.
- **Counters:**
  - 32-bit, saturate at 0xFFFFFFFF.
  - `cnt_clr` wins over increment in the same cycle.
  - STARTUP cycles are not counted.
- `mem_timeout_err` clears only on `rst`.

## Timing
- All RUN and MEM_WAIT outputs are Mealy: combinational from the current inputs and the registered state, valid in the same cycle. No added latency.
- A hazard stall lasts exactly one cycle for load-use (`FORWARD_EN`=1). It lasts up to two cycles for the MEM match (`FORWARD_EN`=0).
- Counters, state and error update on the rising edge after the qualifying cycle. The counters are registered outputs.
- **Reset values while `rst` is high and after release:**
  - state = STARTUP
  - `freeze_if`/`flush_if_id`/`flush_id_ex` = 1
  - `stall_all` = 0
  - `stall_cnt` = `flush_cnt` = 0
  - `mem_timeout_err` = 0
  - init and wait counters = 0
- `rst` asserted during MEM_WAIT returns the block to STARTUP immediately. Outstanding memory state is discarded.
- Index 0 is a valid register. There is no "r0 is zero" exemption.

## Structure
- A shared `pipe_ctrl_pkg` holds:
  - the state enum (STARTUP, RUN, MEM_WAIT)
  - `REG_IDX_W`=4
  - `CNT_W`=32
- Sub-module `hazard_match`: combinational, parameterised by `FORWARD_EN`, outputs `hazard`.
- The FSM, counters and output muxing stay in `pipe_hazard_ctrl`.

## Test plan
- **Reset release, `INIT_FLUSH`=2:** all three flush/freeze outputs are high for 2 cycles, then 0 with idle inputs.
- **Load-use, `FORWARD_EN`=1:**
  - Stimulus: `exe_mem_r_en`=1, `exe_wb_en`=1, `exe_dest`=3, `id_src_1`=3, `id_uses_rn`=1.
  - Response: `freeze_if`=1 and `flush_id_ex`=1 for one cycle, `stall_cnt` increments by 1.
  - With `exe_mem_r_en`=0 instead: no stall.
- **Branch and hazard in the same cycle:** `exe_b`=1 plus the load-use match gives `flush_if_id`=`flush_id_ex`=1, `freeze_if`=0, `flush_cnt`+1.
- **SRAM wait:**
  - Stimulus: `mem_req`=1 with `mem_ready` low for 5 cycles, then high.
  - Response: `stall_all` is high for 5 cycles, low on the ready cycle, and `stall_cnt`+5.
- **Timeout, `MEM_TIMEOUT`=4:** holding `mem_ready` low for 6 cycles sets `mem_timeout_err` after the 4th wait cycle; it stays set after ready.
- **Counter boundaries:**
  - Preload 0xFFFFFFFE via a long stall; the counter stops at 0xFFFFFFFF.
  - `cnt_clr` together with an increment gives 0.
  - `rst` mid-MEM_WAIT goes to STARTUP with `stall_all`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
//   state_t    : controller state encoding (STARTUP, RUN, MEM_WAIT)
//   REG_IDX_W  : register index width of the ARM-subset core
//   CNT_W      : width of the performance-debug counters
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 4;
    localparam int CNT_W     = 32;

    typedef enum logic [1:0] {
        STARTUP  = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_match.sv
// RAW hazard detection between the instruction in ID and the instructions in
// EXE and MEM. Purely combinational.
//   Inputs : ID source indices/valid bits, EXE and MEM destinations with their
//            write-back enables, EXE load flag
//   Outputs: hazard - ID must be held for a cycle
// FORWARD_EN=1: a forwarding unit covers everything except a load in EXE.
// FORWARD_EN=0: any pending write in EXE or MEM to a source register stalls.
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [REG_IDX_W-1:0] id_src_1,
    input  logic [REG_IDX_W-1:0] id_src_2,
    input  logic                 id_uses_rn,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 hazard
);

    logic exe_hit;
    logic mem_hit;

    // Register 0 is an ordinary register here; no zero-register exemption.
    always_comb begin
        exe_hit = exe_wb_en && ((id_uses_rn && (id_src_1 == exe_dest)) ||
                                (id_two_src && (id_src_2 == exe_dest)));
        mem_hit = mem_wb_en && ((id_uses_rn && (id_src_1 == mem_dest)) ||
                                (id_two_src && (id_src_2 == mem_dest)));
        if (FORWARD_EN) begin
            hazard = exe_mem_r_en && exe_hit;
        end else begin
            hazard = exe_hit || mem_hit;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Flush / freeze / global-stall generation for the IF/ID and ID/EX stage
// registers, plus saturating stall and branch-flush counters.
//   Inputs : ID sources, EXE/MEM destinations, taken branch, SRAM handshake,
//            counter clear
//   Outputs: freeze_if, flush_if_id, flush_id_ex, stall_all (Mealy),
//            stall_cnt, flush_cnt (registered), mem_timeout_err (sticky)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   STARTUP  | flush both stage registers for INIT_FLUSH cycles after reset
//   RUN      | normal issue: memory wait > branch flush > hazard stall
//   MEM_WAIT | SRAM busy, whole pipeline held until mem_ready
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN  = 1'b1,
    parameter int INIT_FLUSH  = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src_1,
    input  logic [REG_IDX_W-1:0] id_src_2,
    input  logic                 id_uses_rn,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic                 exe_b,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 cnt_clr,
    output logic                 freeze_if,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 stall_all,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 mem_timeout_err
);

    state_t             state_q, state_d;
    logic [3:0]         init_cnt_q, init_cnt_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               hazard;
    logic               run_rules;
    logic               branch_flush;
    logic               stall_inc;

    hazard_match #(.FORWARD_EN(FORWARD_EN)) u_hazard_match (
        .id_src_1     (id_src_1),
        .id_src_2     (id_src_2),
        .id_uses_rn   (id_uses_rn),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        freeze_if    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        stall_all    = 1'b0;
        run_rules    = 1'b0;
        branch_flush = 1'b0;

        case (state_q)
            STARTUP: begin
                freeze_if   = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                init_cnt_d  = init_cnt_q + 4'd1;
                if (init_cnt_d == 4'(INIT_FLUSH)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                run_rules = 1'b1;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Ready cycle releases the hold and is treated as RUN.
                    run_rules = 1'b1;
                end else begin
                    stall_all = 1'b1;
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (wait_cnt_d == 16'(MEM_TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = STARTUP;
            end
        endcase

        if (run_rules) begin
            state_d = RUN;
            if (mem_req && !mem_ready) begin
                stall_all  = 1'b1;
                wait_cnt_d = '0;
                state_d    = MEM_WAIT;
            end else if (exe_b) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                branch_flush = 1'b1;
            end else if (hazard) begin
                freeze_if   = 1'b1;
                flush_id_ex = 1'b1;
            end
        end

        // STARTUP drives freeze_if but is not a performance stall.
        stall_inc = (state_q != STARTUP) && (freeze_if || stall_all);

        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (cnt_clr) begin
            flush_cnt_d = '0;
        end else if (branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STARTUP;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;
    assign mem_timeout_err = err_q;

endmodule
